// File: rtl/spi_slave_rx.sv
// SPI slave receiver: oversampled pins, word assembly, and a first-word
// fall-through FIFO with a valid/ready read port.
module spi_slave_rx #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          spi_cs_l,
    input  logic                          spi_sclk,
    input  logic                          spi_mosi,
    output logic [DATA_W-1:0]             rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [$clog2(DATA_W)-1:0]     bit_count,
    output logic                          busy,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int          AW    = $clog2(FIFO_DEPTH);
    localparam int          LW    = AW + 1;
    localparam int          CW    = $clog2(DATA_W);
    localparam int unsigned NSYNC = SYNC_STAGES;

    typedef enum logic {IDLE, SHIFT} state_t;

    // {cs_l, sclk, mosi} after the synchroniser; all three share one delay
    logic [2:0] pins_s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign pins_s = {spi_cs_l, spi_sclk, spi_mosi};
        end else begin : g_sync
            logic [2:0] sync_q [SYNC_STAGES];
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int unsigned i = 0; i < NSYNC; i++) sync_q[i] <= '0;
                end else begin
                    sync_q[0] <= {spi_cs_l, spi_sclk, spi_mosi};
                    for (int unsigned i = 1; i < NSYNC; i++) sync_q[i] <= sync_q[i-1];
                end
            end
            assign pins_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    logic [1:0]        prev_q;
    logic              cs_fall, cs_rise, sclk_rise;
    state_t            state_q;
    logic [DATA_W-1:0] shreg_q;
    logic [CW-1:0]     bit_cnt_q;
    logic              frame_err_q;
    logic              word_done;
    logic [DATA_W-1:0] word_d;

    assign cs_fall   =  prev_q[1] & ~pins_s[2];
    assign cs_rise   = ~prev_q[1] &  pins_s[2];
    assign sclk_rise = ~prev_q[0] &  pins_s[1];
    assign word_d    = {shreg_q[DATA_W-2:0], pins_s[0]};
    assign word_done = (state_q == SHIFT) && !cs_rise && sclk_rise &&
                       (bit_cnt_q == CW'(DATA_W-1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) prev_q <= '0;
        else       prev_q <= pins_s[2:1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_q <= SHIFT;
                        // an SCLK rise coinciding with the CS fall is bit 1
                        if (sclk_rise) begin
                            shreg_q   <= word_d;
                            bit_cnt_q <= CW'(1);
                        end else begin
                            bit_cnt_q <= '0;
                        end
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state_q     <= IDLE;
                        bit_cnt_q   <= '0;
                        frame_err_q <= (bit_cnt_q != '0);
                    end else if (sclk_rise) begin
                        shreg_q   <= word_d;
                        bit_cnt_q <= word_done ? '0 : bit_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_q, rd_q;
    logic [LW-1:0]     level_q;
    logic              overflow_q;
    logic              pop, full, wr_en;

    assign pop   = rx_valid & rx_ready;
    assign full  = (level_q == LW'(FIFO_DEPTH));
    assign wr_en = word_done & (~full | pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= word_done & full & ~pop;
            if (wr_en) begin
                mem_q[wr_q] <= word_d;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            unique case ({wr_en, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    assign rx_data    = mem_q[rd_q];
    assign rx_valid   = (level_q != '0);
    assign fifo_level = level_q;
    assign bit_count  = bit_cnt_q;
    assign busy       = (state_q == SHIFT);
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: a clk-synchronous instance (no sync stages)
// for the frame/FIFO corner cases and a 2-stage instance driven asynchronously.
`timescale 1ps/1ps
module tb_spi_slave_rx;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5000 clk = ~clk;

    logic        cs0 = 1'b1, sclk0 = 1'b0, mosi0 = 1'b0, rdy0 = 1'b0;
    logic [15:0] d0;
    logic        v0, busy0, fe0, ov0;
    logic [2:0]  lvl0;
    logic [3:0]  bc0;

    logic        cs2 = 1'b1, sclk2 = 1'b0, mosi2 = 1'b0, rdy2 = 1'b1;
    logic [15:0] d2;
    logic        v2, busy2, fe2, ov2;
    logic [2:0]  lvl2;
    logic [3:0]  bc2;

    spi_slave_rx #(.DATA_W(16), .SYNC_STAGES(0), .FIFO_DEPTH(4)) dut0 (
        .clk(clk), .reset(reset), .spi_cs_l(cs0), .spi_sclk(sclk0), .spi_mosi(mosi0),
        .rx_data(d0), .rx_valid(v0), .rx_ready(rdy0), .fifo_level(lvl0),
        .bit_count(bc0), .busy(busy0), .frame_err(fe0), .overflow(ov0));

    spi_slave_rx #(.DATA_W(16), .SYNC_STAGES(2), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .reset(reset), .spi_cs_l(cs2), .spi_sclk(sclk2), .spi_mosi(mosi2),
        .rx_data(d2), .rx_valid(v2), .rx_ready(rdy2), .fifo_level(lvl2),
        .bit_count(bc2), .busy(busy2), .frame_err(fe2), .overflow(ov2));

    int n_checks = 0;
    int n_pass   = 0;
    int fe_cnt = 0, fe_run = 0, fe_max = 0;
    int ov_cnt = 0, ov_run = 0, ov_max = 0;
    int vcyc0 = 0;
    int fe2_cnt = 0, ov2_cnt = 0;
    logic [15:0] popq0 [$];
    logic [15:0] popq2 [$];
    logic [15:0] exp2  [$];

    // Sample mid-low-phase: inputs driven at negedge are settled, next posedge not yet reached
    always begin
        @(negedge clk);
        #2000;
        if (v0 && rdy0) popq0.push_back(d0);
        if (v0) vcyc0++;
        if (fe0) begin
            fe_cnt++; fe_run++;
            if (fe_run > fe_max) fe_max = fe_run;
        end else fe_run = 0;
        if (ov0) begin
            ov_cnt++; ov_run++;
            if (ov_run > ov_max) ov_max = ov_run;
        end else ov_run = 0;
        if (v2 && rdy2) popq2.push_back(d2);
        if (fe2) fe2_cnt++;
        if (ov2) ov2_cnt++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    task automatic clr0();
        popq0.delete();
        fe_cnt = 0; fe_max = 0; ov_cnt = 0; ov_max = 0; vcyc0 = 0;
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic settle(input int c);
        repeat (c) @(negedge clk);
        #3000;
    endtask

    task automatic cs_low0();
        @(negedge clk); cs0 = 1'b0;
    endtask

    task automatic bit0(input logic b, input bit pop);
        @(negedge clk); mosi0 = b; sclk0 = 1'b0;
        @(negedge clk); sclk0 = 1'b1;
        if (pop) rdy0 = 1'b1;
    endtask

    task automatic cs_high0(input bit pop);
        @(negedge clk); sclk0 = 1'b0;
        if (pop) rdy0 = 1'b0;
        @(negedge clk); cs0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic send0(input logic [31:0] d, input int n, input bit pop_last);
        cs_low0();
        for (int i = n - 1; i >= 0; i--) bit0(d[i], pop_last && (i == 0));
        cs_high0(pop_last);
    endtask

    task automatic pop_one();
        @(negedge clk); rdy0 = 1'b1;
        @(negedge clk); rdy0 = 1'b0;
        #3000;
    endtask

    task automatic async_master(input int nwords);
        int sent = 0;
        logic [15:0] w;
        #($urandom_range(0, 9999));
        while (sent < nwords) begin
            int k = $urandom_range(1, 3);
            if (k > nwords - sent) k = nwords - sent;
            cs2 = 1'b0;
            for (int j = 0; j < k; j++) begin
                w = 16'($urandom);
                exp2.push_back(w);
                for (int b = 15; b >= 0; b--) begin
                    mosi2 = w[b];
                    #30000 sclk2 = 1'b1;
                    #30000 sclk2 = 1'b0;
                end
            end
            sent += k;
            #30000 cs2 = 1'b1;
            #(30000 + $urandom_range(0, 9999));
        end
    endtask

    typedef struct {
        logic [31:0] d;
        int          n;
        int          words;
        logic [15:0] w0;
        logic [15:0] w1;
        int          fe;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs[0] = '{32'h0000A5C3, 16, 1, 16'hA5C3, 16'h0000, 0};
        vecs[1] = '{32'h00000000, 16, 1, 16'h0000, 16'h0000, 0};
        vecs[2] = '{32'h0000FFFF, 16, 1, 16'hFFFF, 16'h0000, 0};
        vecs[3] = '{32'h00008001, 16, 1, 16'h8001, 16'h0000, 0};
        vecs[4] = '{32'h1234FFFF, 32, 2, 16'h1234, 16'hFFFF, 0};
        vecs[5] = '{32'h000001FF,  9, 0, 16'h0000, 16'h0000, 1};
        vecs[6] = '{32'h00000001,  1, 0, 16'h0000, 16'h0000, 1};
        vecs[7] = '{32'h00007FFF, 15, 0, 16'h0000, 16'h0000, 1};
        vecs[8] = '{32'h00000000,  0, 0, 16'h0000, 16'h0000, 0};
        vecs[9] = '{32'h0001A5C3, 17, 1, 16'hD2E1, 16'h0000, 1};

        // reset state
        repeat (2) @(negedge clk);
        #3000;
        check("rst_rx_data", d0, 0);
        check("rst_rx_valid", v0, 0);
        check("rst_level", lvl0, 0);
        check("rst_bit_count", bc0, 0);
        check("rst_busy", busy0, 0);
        check("rst_frame_err", fe0, 0);
        check("rst_overflow", ov0, 0);
        @(negedge clk); reset = 1'b0;
        settle(2);

        // single-frame vectors, consumer always ready
        rdy0 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            clr0();
            send0(vecs[i].d, vecs[i].n, 1'b0);
            settle(3);
            check($sformatf("v%0d_pops", i), popq0.size(), vecs[i].words);
            if (vecs[i].words > 0) check($sformatf("v%0d_w0", i), popq0[0], vecs[i].w0);
            if (vecs[i].words > 1) check($sformatf("v%0d_w1", i), popq0[1], vecs[i].w1);
            if (vecs[i].words == 1) check($sformatf("v%0d_valid_cycles", i), vcyc0, 1);
            check($sformatf("v%0d_frame_err", i), fe_cnt, vecs[i].fe);
            if (vecs[i].fe > 0) check($sformatf("v%0d_fe_width", i), fe_max, 1);
            check($sformatf("v%0d_overflow", i), ov_cnt, 0);
            check($sformatf("v%0d_busy", i), busy0, 0);
            check($sformatf("v%0d_level", i), lvl0, 0);
        end
        rdy0 = 1'b0;

        // two words in one frame held in FIFO
        clr0();
        send0(32'h1234FFFF, 32, 1'b0);
        settle(2);
        check("t2_level", lvl0, 2);
        check("t2_head", d0, 16'h1234);
        check("t2_frame_err", fe_cnt, 0);
        pop_one();
        check("t2_head2", d0, 16'hFFFF);
        check("t2_level1", lvl0, 1);
        pop_one();
        check("t2_level0", lvl0, 0);
        check("t2_valid0", v0, 0);
        check("t2_pop_order", {popq0[0], popq0[1]}, 32'h1234FFFF);

        // short frame between good words
        clr0();
        send0(32'h5555, 16, 1'b0);
        send0(32'h155, 9, 1'b0);
        settle(2);
        check("t3_level", lvl0, 1);
        check("t3_fe_count", fe_cnt, 1);
        check("t3_fe_width", fe_max, 1);
        send0(32'h0001, 16, 1'b0);
        settle(2);
        check("t3_level2", lvl0, 2);
        pop_one();
        pop_one();
        check("t3_words", {popq0[0], popq0[1]}, 32'h55550001);

        // overflow, then full+push+pop in the same cycle
        do_reset();
        clr0();
        send0(32'h1111, 16, 1'b0);
        send0(32'h2222, 16, 1'b0);
        send0(32'h3333, 16, 1'b0);
        send0(32'h4444, 16, 1'b0);
        settle(2);
        check("t4_level_full", lvl0, 4);
        check("t4_no_ovf_yet", ov_cnt, 0);
        send0(32'hDEAD, 16, 1'b0);
        settle(2);
        check("t4_ovf_count", ov_cnt, 1);
        check("t4_ovf_width", ov_max, 1);
        check("t4_level_after_ovf", lvl0, 4);
        check("t4_head_after_ovf", d0, 16'h1111);
        send0(32'hDEAD, 16, 1'b1);
        settle(2);
        check("t4_ovf_pushpop", ov_cnt, 1);
        check("t4_level_pushpop", lvl0, 4);
        check("t4_head_pushpop", d0, 16'h2222);
        @(negedge clk); rdy0 = 1'b1;
        settle(6);
        rdy0 = 1'b0;
        check("t4_drain_count", popq0.size(), 5);
        check("t4_tail", popq0[4], 16'hDEAD);
        check("t4_before_tail", popq0[3], 16'h4444);

        // reset mid-frame with CS held low
        do_reset();
        clr0();
        cs_low0();
        for (int i = 15; i >= 9; i--) bit0(1'b1, 1'b0);
        @(negedge clk); sclk0 = 1'b0;
        #3000;
        check("t5_bit_count_7", bc0, 7);
        check("t5_busy_mid", busy0, 1);
        @(negedge clk); reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #3000;
        check("t5_bc_after_rst", bc0, 0);
        check("t5_busy_after_rst", busy0, 0);
        for (int i = 8; i >= 0; i--) bit0(1'b1, 1'b0);
        cs_high0(1'b0);
        settle(2);
        check("t5_no_push", lvl0, 0);
        check("t5_no_fe", fe_cnt, 0);
        send0(32'h8001, 16, 1'b0);
        settle(2);
        check("t5_level", lvl0, 1);
        check("t5_word", d0, 16'h8001);

        // asynchronous master into the synchronised instance
        async_master(100);
        begin
            int t = 0;
            while (popq2.size() < 100 && t < 500) begin
                @(negedge clk);
                t++;
            end
        end
        #3000;
        check("t6_word_count", popq2.size(), 100);
        for (int i = 0; i < 100; i++)
            check($sformatf("t6_word%0d", i), popq2[i], exp2[i]);
        check("t6_frame_err", fe2_cnt, 0);
        check("t6_overflow", ov2_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
